// File: rtl/unsigned_div_16by8_seq_if.sv
// Operand/result handshake bundle for unsigned_div_16by8_seq.
// The remainder signal exists only when DIV_REMAINDER_EN is defined.
interface unsigned_div_16by8_seq_if #(
    parameter int unsigned DW_N = 16,
    parameter int unsigned DW_D = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW_N-1:0] quotient;
`ifdef DIV_REMAINDER_EN
    logic [DW_D-1:0] remainder;
`endif
    logic            div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient,
`ifdef DIV_REMAINDER_EN
        input  remainder,
`endif
        input  div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient,
`ifdef DIV_REMAINDER_EN
        output remainder,
`endif
        output div_by_zero
    );
endinterface

// File: rtl/unsigned_div_16by8_seq.sv
// Sequential restoring radix-2 unsigned divider, one quotient bit per cycle, MSB first.
// TRUNC_BITS quotient LSBs are skipped (forced 0) for a shorter, approximate division.
// Optional feature macro: DIV_REMAINDER_EN adds the remainder output and its register.
module unsigned_div_16by8_seq #(
    parameter int unsigned DW_N       = 16,
    parameter int unsigned DW_D       = 8,
    parameter int unsigned TRUNC_BITS = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    unsigned_div_16by8_seq_if.slave bus_io
);

    localparam int unsigned NIter = DW_N - TRUNC_BITS;
    localparam int unsigned CntW  = $clog2(DW_N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [DW_N-1:0] a_q, a_d;        // dividend, shifted out MSB first
    logic [DW_D-1:0] b_q, b_d;        // latched divisor
    logic [DW_D-1:0] p_q, p_d;        // partial remainder
    logic [DW_N-1:0] q_q, q_d;        // quotient bits collected so far
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW_N-1:0] quot_q, quot_d;
    logic            dbz_q, dbz_d;
`ifdef DIV_REMAINDER_EN
    logic [DW_D-1:0] rem_q, rem_d;
`endif

    logic accept, divisor_zero, last_iter;

    assign accept       = bus_io.in_valid & in_ready_q;
    assign divisor_zero = (bus_io.divisor == '0);
    assign last_iter    = (state_q == StRun) && (cnt_q == CntW'(1));

    logic [DW_D:0]   p_shift;
    logic            q_bit;
    logic [DW_D-1:0] p_next;
    logic [DW_N-1:0] q_next;

    // One restoring step on the current partial remainder
    always_comb begin
        p_shift = {p_q, a_q[DW_N-1]};
        q_bit   = (p_shift >= {1'b0, b_q});
        // A successful subtract leaves a value below the divisor, so DW_D bits suffice
        p_next  = q_bit ? (p_shift[DW_D-1:0] - b_q) : p_shift[DW_D-1:0];
        q_next  = (q_q << 1) | DW_N'(q_bit);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE, divide-by-zero skips RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = divisor_zero ? StDone : StRun;
            StRun:  if (last_iter) state_d = StDone;
            StDone: if (out_valid_q && bus_io.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state; handshake flags follow the next state
    always_comb begin
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        quot_d      = quot_q;
        dbz_d       = dbz_q;
`ifdef DIV_REMAINDER_EN
        rem_d       = rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d   = bus_io.dividend;
                    b_d   = bus_io.divisor;
                    p_d   = '0;
                    q_d   = '0;
                    cnt_d = CntW'(NIter);
                    dbz_d = divisor_zero;
                    if (divisor_zero) begin
                        quot_d = '1;
`ifdef DIV_REMAINDER_EN
                        rem_d  = bus_io.dividend[DW_D-1:0];
`endif
                    end
                end
            end
            StRun: begin
                a_d   = a_q << 1;
                p_d   = p_next;
                q_d   = q_next;
                cnt_d = cnt_q - 1'b1;
                if (last_iter) begin
                    quot_d = q_next << TRUNC_BITS;
`ifdef DIV_REMAINDER_EN
                    rem_d  = (TRUNC_BITS == 0) ? p_next : '0;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath and handshake registers; reset clears every visible output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            quot_q      <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_q       <= '0;
`endif
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            quot_q      <= quot_d;
            dbz_q       <= dbz_d;
`ifdef DIV_REMAINDER_EN
            rem_q       <= rem_d;
`endif
        end
    end

    assign bus_io.in_ready    = in_ready_q;
    assign bus_io.out_valid   = out_valid_q;
    assign bus_io.quotient    = quot_q;
    assign bus_io.div_by_zero = dbz_q;
`ifdef DIV_REMAINDER_EN
    assign bus_io.remainder   = rem_q;
`endif

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Directed bench for unsigned_div_16by8_seq: exact instance (TRUNC_BITS=0) and a
// truncated instance (TRUNC_BITS=4) sharing clock and reset.
module tb_unsigned_div_16by8_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    unsigned_div_16by8_seq_if #(.DW_N(16), .DW_D(8)) if0 ();
    unsigned_div_16by8_seq_if #(.DW_N(16), .DW_D(8)) if1 ();

    unsigned_div_16by8_seq #(.DW_N(16), .DW_D(8), .TRUNC_BITS(0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (if0.slave)
    );

    unsigned_div_16by8_seq #(.DW_N(16), .DW_D(8), .TRUNC_BITS(4)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (if1.slave)
    );

    // Shared stimulus, steered to one instance by sel
    logic        sel;
    logic        in_valid;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_ready;

    assign if0.in_valid  = (sel == 1'b0) && in_valid;
    assign if1.in_valid  = (sel == 1'b1) && in_valid;
    assign if0.out_ready = (sel == 1'b0) && out_ready;
    assign if1.out_ready = (sel == 1'b1) && out_ready;
    assign if0.dividend  = dividend;
    assign if1.dividend  = dividend;
    assign if0.divisor   = divisor;
    assign if1.divisor   = divisor;

    logic        g_in_ready, g_out_valid, g_dbz;
    logic [15:0] g_quot;
    logic [7:0]  g_rem;

    // Observe the selected instance
    always_comb begin
        g_in_ready  = sel ? if1.in_ready    : if0.in_ready;
        g_out_valid = sel ? if1.out_valid   : if0.out_valid;
        g_dbz       = sel ? if1.div_by_zero : if0.div_by_zero;
        g_quot      = sel ? if1.quotient    : if0.quotient;
`ifdef DIV_REMAINDER_EN
        g_rem       = sel ? if1.remainder   : if0.remainder;
`else
        g_rem       = 8'h00;
`endif
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!g_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(g_in_ready), 32'd1);
    endtask

    // One full transaction: accept, measure latency, check result, complete handshake
    task automatic run_op(input logic s, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_dbz, input int exp_lat);
        int lat = 0;
        sel = s;
        wait_ready();
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = ~a;             // late operand changes must not matter
        divisor  = b ^ 8'h5A;
        do begin
            @(negedge clk);
            lat++;
        end while (!g_out_valid && lat < 40);
        check("latency", 32'(lat), 32'(exp_lat));
        check("quotient", 32'(g_quot), 32'(exp_q));
        check("div_by_zero", 32'(g_dbz), 32'(exp_dbz));
`ifdef DIV_REMAINDER_EN
        check("remainder", 32'(g_rem), 32'(exp_r));
`else
        if (exp_r != g_rem) begin end
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", 32'(g_out_valid), 32'd0);
        check("in_ready_after_hs", 32'(g_in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        int          n;

        sel       = 1'b0;
        in_valid  = 1'b0;
        dividend  = 16'h0;
        divisor   = 8'h0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(g_in_ready), 32'd0);
        check("rst_out_valid", 32'(g_out_valid), 32'd0);
        check("rst_quotient", 32'(g_quot), 32'd0);
        check("rst_dbz", 32'(g_dbz), 32'd0);
        check("rst_remainder", 32'(g_rem), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(g_in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(g_in_ready), 32'd1);

        // Directed exact divisions
        run_op(1'b0, 16'd200,   8'd7,   16'd28,    8'd4,    1'b0, 17);
        run_op(1'b0, 16'd65535, 8'd255, 16'd257,   8'd0,    1'b0, 17);
        run_op(1'b0, 16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 17);
        run_op(1'b0, 16'd1234,  8'd0,   16'hFFFF,  8'hD2,   1'b1, 1);
        run_op(1'b0, 16'd0,     8'd5,   16'd0,     8'd0,    1'b0, 17);
        run_op(1'b0, 16'd255,   8'd16,  16'd15,    8'd15,   1'b0, 17);
        run_op(1'b0, 16'd12345, 8'd123, 16'd100,   8'd45,   1'b0, 17);
        run_op(1'b0, 16'd40000, 8'd200, 16'd200,   8'd0,    1'b0, 17);

        // Backpressure: result held, new operands ignored
        sel = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!g_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(g_out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 16'd5;
            divisor  = 8'd1;
            check("bp_out_valid", 32'(g_out_valid), 32'd1);
            check("bp_in_ready", 32'(g_in_ready), 32'd0);
            check("bp_quotient", 32'(g_quot), 32'd142);
            check("bp_remainder", 32'(g_rem), `ifdef DIV_REMAINDER_EN 32'd6 `else 32'd0 `endif);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_ready_after_hs", 32'(g_in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("bp_no_queue", 32'(g_out_valid), 32'd0);
        check("bp_quot_held", 32'(g_quot), 32'd142);

        // Reset during RUN aborts and clears outputs
        wait_ready();
        in_valid = 1'b1;
        dividend = 16'd500;
        divisor  = 8'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(g_in_ready), 32'd0);
        check("abort_out_valid", 32'(g_out_valid), 32'd0);
        check("abort_quotient", 32'(g_quot), 32'd0);
        check("abort_dbz", 32'(g_dbz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 17);

        // Random exact divisions against a floor model
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            run_op(1'b0, ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0, 17);
        end

        // Truncated instance: four LSBs cleared, 12 iterations
        run_op(1'b1, 16'd1000,  8'd3, 16'h0140, 8'd0, 1'b0, 13);
        run_op(1'b1, 16'd65535, 8'd1, 16'hFFF0, 8'd0, 1'b0, 13);
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            run_op(1'b1, ra, rb, (ra / 16'(rb)) & 16'hFFF0, 8'd0, 1'b0, 13);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
